// File: rtl/reu_xfer_seq.sv
// reu_xfer_seq -- REU DMA transfer sequencer.
//
// Takes the C64 bus through nDMA and moves one byte per PHI2 cycle between C64
// memory and REU RAM: stash, fetch, swap or verify. Bus strobes and the
// Next*/XferEnd/VerifyErr pulses are decoded from the registered state and the
// live BA input, so a BA=0 cycle is a clean wait cycle. nDMA and Busy are
// registered alongside the state. State changes on the falling edge of PHI2.
//
// Ports
//   PHI2, Reset                     clock (falling edge), synchronous active-high reset
//   ExecuteEN, XferType,
//   FF00DecodeEN, FF00WR, Length1   command inputs from the register block
//   BA                              VIC bus-available, 0 stalls
//   C64DIn, RAMDIn                  data bus samples
//   nDMA, Busy                      registered DMA request / transfer-active
//   C64AOE, C64RnW, C64DOut         C64 bus control and write data
//   RAMRD, RAMWR, RAMDOut           REU RAM strobes and write data
//   NextCA, NextREUA, XferEnd,
//   VerifyErr                       one-cycle status pulses
module reu_xfer_seq #(
  parameter int DMA_SETUP   = 2,
  parameter bit VERIFY_STOP = 1'b1,
  parameter int DATA_W      = 8
) (
  input  logic              PHI2,
  input  logic              Reset,
  input  logic              ExecuteEN,
  input  logic [1:0]        XferType,
  input  logic              FF00DecodeEN,
  input  logic              FF00WR,
  input  logic              Length1,
  input  logic              BA,
  input  logic [DATA_W-1:0] C64DIn,
  input  logic [DATA_W-1:0] RAMDIn,
  output logic              nDMA,
  output logic              Busy,
  output logic              C64AOE,
  output logic              C64RnW,
  output logic [DATA_W-1:0] C64DOut,
  output logic              RAMRD,
  output logic              RAMWR,
  output logic [DATA_W-1:0] RAMDOut,
  output logic              NextCA,
  output logic              NextREUA,
  output logic              XferEnd,
  output logic              VerifyErr
);

  typedef enum logic [2:0] {IDLE, ARM, SETUP, XFER, SWAPW, DONE} state_t;

  localparam logic [1:0] T_STASH  = 2'b00;
  localparam logic [1:0] T_FETCH  = 2'b01;
  localparam logic [1:0] T_SWAP   = 2'b10;
  localparam logic [1:0] T_VERIFY = 2'b11;

  state_t            state;
  state_t            stateNext;
  logic [7:0]        setupCnt;
  logic [DATA_W-1:0] c64Latch;
  logic [DATA_W-1:0] ramLatch;

  logic xferBa;
  logic swapBa;
  logic byteDone;
  logic mismatch;
  logic dmaNext;

  // Active bus cycles; Reset masks everything so an aborted cycle has no effect.
  assign xferBa   = (state == XFER)  && BA && !Reset;
  assign swapBa   = (state == SWAPW) && BA && !Reset;
  // A swap byte completes in its second (write-back) cycle.
  assign byteDone = (xferBa && (XferType != T_SWAP)) || swapBa;
  assign mismatch = xferBa && (XferType == T_VERIFY) && (C64DIn != RAMDIn);

  assign NextCA    = byteDone;
  assign NextREUA  = byteDone;
  assign XferEnd   = byteDone && Length1;
  assign VerifyErr = mismatch;

  assign C64AOE  = xferBa || swapBa;
  assign C64RnW  = !((xferBa && (XferType == T_FETCH)) || swapBa);
  assign RAMRD   = xferBa && (XferType != T_STASH);
  assign RAMWR   = (xferBa && (XferType == T_STASH)) || swapBa;
  assign C64DOut = (XferType == T_FETCH) ? RAMDIn : ramLatch;
  assign RAMDOut = (XferType == T_STASH) ? C64DIn : c64Latch;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (ExecuteEN) stateNext = FF00DecodeEN ? ARM : SETUP;
      ARM: begin
        if (!ExecuteEN)  stateNext = IDLE;
        else if (FF00WR) stateNext = SETUP;
      end
      SETUP: if (BA && (setupCnt == 8'(DMA_SETUP - 1))) stateNext = XFER;
      XFER: begin
        if (BA) begin
          if (XferType == T_SWAP)            stateNext = SWAPW;
          else if (Length1)                  stateNext = DONE;
          else if (mismatch && VERIFY_STOP)  stateNext = DONE;
        end
      end
      SWAPW: if (BA) stateNext = Length1 ? DONE : XFER;
      DONE:  if (!ExecuteEN) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign dmaNext = (stateNext == SETUP) || (stateNext == XFER) || (stateNext == SWAPW);

  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state    <= IDLE;
      setupCnt <= 8'd0;
      c64Latch <= '0;
      ramLatch <= '0;
      nDMA     <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      state <= stateNext;
      nDMA  <= !dmaNext;
      Busy  <= dmaNext;
      // Halt-latency counter only advances while the VIC releases the bus.
      if (state != SETUP)
        setupCnt <= 8'd0;
      else if (BA)
        setupCnt <= setupCnt + 8'd1;
      if (xferBa && (XferType == T_SWAP)) begin
        c64Latch <= C64DIn;
        ramLatch <= RAMDIn;
      end
    end
  end

endmodule
